// File: rtl/riscv_mon_pkg.sv
// Shared constants for the riscv-tests end-of-test monitor: FSM state encoding
// and default completion addresses.
package riscv_mon_pkg;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] CHECK = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [31:0] END_PC_DEF      = 32'h44;
   localparam logic [31:0] TOHOST_ADDR_DEF = 32'h1000;
endpackage

// File: rtl/riscv_mon_timer.sv
// Saturating RUN-cycle counter; expire_o flags the last permitted RUN cycle.
module riscv_mon_timer #(
   parameter int TIMEOUT = 5000,
   parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             enable_i,
   output logic [CNT_W-1:0] count_o,
   output logic             expire_o
);
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i)
         count_d = '0;
      else if (enable_i && count_q != CNT_W'(TIMEOUT))
         count_d = count_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count_o  = count_q;
   assign expire_o = enable_i && (count_q == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/riscv_test_monitor.sv
// End-of-test monitor: PC-trap completion, optional tohost-store completion
// (macro RISCV_MON_TOHOST_EN), sticky pass/fail/timeout verdict flags.
module riscv_test_monitor
   import riscv_mon_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] END_PC      = XLEN'(END_PC_DEF),
   parameter int              TIMEOUT     = 5000,
   parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(TOHOST_ADDR_DEF),
   parameter int              CNT_W       = $clog2(TIMEOUT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [XLEN-1:0]  pc,
   input  logic             pc_valid,
   input  logic [XLEN-1:0]  gp,
   input  logic             st_valid,
   input  logic [XLEN-1:0]  st_addr,
   input  logic [XLEN-1:0]  st_data,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic [XLEN-2:0]  test_num,
   output logic [CNT_W-1:0] cycles
);
   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] gp_q, gp_d;
   logic [XLEN-2:0] test_num_q, test_num_d;
   logic            pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d;
   logic            pc_hit, tohost_hit, hit, arm, expire;

   assign pc_hit = pc_valid && (pc == END_PC);
`ifdef RISCV_MON_TOHOST_EN
   assign tohost_hit = st_valid && (st_addr == TOHOST_ADDR) && st_data[0];
`else
   logic unused_st;
   assign tohost_hit = 1'b0;
   assign unused_st  = ^{st_valid, st_addr, st_data, TOHOST_ADDR};
`endif
   assign hit = pc_hit || tohost_hit;
   // Re-arm only from a quiescent state; start mid-run is ignored.
   assign arm = start && (state_q == IDLE || state_q == DONE);

   riscv_mon_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (arm),
      .enable_i (state_q == RUN),
      .count_o  (cycles),
      .expire_o (expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         gp_q       <= '0;
         test_num_q <= '0;
         pass_q     <= 1'b0;
         fail_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         gp_q       <= gp_d;
         test_num_q <= test_num_d;
         pass_q     <= pass_d;
         fail_q     <= fail_d;
         timeout_q  <= timeout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (hit) state_d = CHECK;
                  else if (expire) state_d = DONE;
         CHECK:   state_d = DONE;
         DONE:    if (start) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      gp_d       = gp_q;
      test_num_d = test_num_q;
      pass_d     = pass_q;
      fail_d     = fail_q;
      timeout_d  = timeout_q;
      if (arm) begin
         test_num_d = '0;
         pass_d     = 1'b0;
         fail_d     = 1'b0;
         timeout_d  = 1'b0;
      end else if (state_q == RUN) begin
         // A completion in the expiry cycle wins over the timeout.
         if (hit)         gp_d      = tohost_hit ? st_data : gp;
         else if (expire) timeout_d = 1'b1;
      end else if (state_q == CHECK) begin
         if (gp_q == XLEN'(1)) begin
            pass_d = 1'b1;
         end else begin
            fail_d     = 1'b1;
            test_num_d = gp_q[XLEN-1:1];
         end
      end
   end

   assign busy     = (state_q == RUN) || (state_q == CHECK);
   assign pass     = pass_q;
   assign fail     = fail_q;
   assign timeout  = timeout_q;
   assign done     = pass_q | fail_q | timeout_q;
   assign test_num = test_num_q;
endmodule
